cpu_mem_arbiter: RTL and testbench
==================================

# cpu_mem_arbiter

Arbiter and sequencer that shares the cpu's single-ported memory between the instruction-fetch (IF) and load/store (LS) requesters. Accepts one request at a time, drives one memory command, waits the fixed memory latency, and returns the read data to the winning requester. It sits inside `cpu`, between the fetch/LSU logic and the memory model. Ties are resolved round-robin, so neither requester can starve the other.

## Interface
- `AW`, 8: address width.
- `DW`, 32: data width.
- `MEM_LAT`, 1: cycles from the `mem_en` cycle to valid `mem_rdata`. Legal range is 1..15; elaboration fails outside it.

- `clk`  input  1  clock, rising edge.
- `resetn`  input  1  asynchronous active-low reset.
- `if_req`  input  1  IF read request.
- `if_addr`  input  AW  IF address.
- `if_gnt`  output  1  IF request accepted (combinational).
- `if_rvalid`  output  1  one-cycle IF read-data strobe.
- `if_rdata`  output  DW  IF read data.
- `ls_req`  input  1  LS request.
- `ls_we`  input  1  LS write enable (1 = write).
- `ls_addr`  input  AW  LS address.
- `ls_wdata`  input  DW  LS write data.
- `ls_gnt`  output  1  LS request accepted (combinational).
- `ls_rvalid`  output  1  one-cycle LS completion strobe, for reads and writes.
- `ls_rdata`  output  DW  LS read data.
- `mem_en`  output  1  memory command strobe.
- `mem_we`  output  1  memory write enable.
- `mem_addr`  output  AW  memory address.
- `mem_wdata`  output  DW  memory write data.
- `mem_rdata`  input  DW  memory read data.
- `arb_busy`  output  1  high whenever the FSM is not in IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP. Reset puts it in IDLE.
- **IDLE:**
  - If only one requester has `req` high, that requester is granted.
  - If both are high, the requester not granted most recently wins. `last_owner` resets to LS, so the first tie goes to IF.
  - The winner's `gnt` is high combinationally in this cycle only.
  - On that same edge the block latches the owner and the command (`addr`; for LS also `we` and `wdata`; IF always has `we=0`), updates `last_owner`, and moves to ISSUE.
- **ISSUE** (1 cycle): `mem_en=1`, and `mem_we`, `mem_addr`, `mem_wdata` come from the latched command. Load the latency counter with `MEM_LAT` and move to WAIT.
- **WAIT** (`MEM_LAT` cycles):
  - Decrement the counter each cycle.
  - On the final WAIT cycle, register `mem_rdata` into the owner's `rdata` register, but only for reads. Writes leave `rdata` unchanged.
  - Then move to RESP.
- **RESP** (1 cycle): the owner's `rvalid=1`, then return to IDLE.
- Outside IDLE both `gnt` outputs are 0 regardless of `req`.
- **Requester rules:**
  - Each requester holds `req`, `addr`, `we` and `wdata` stable until it sees `gnt`.
  - Dropping `req` before `gnt` withdraws the request with no side effects.
  - After `gnt`, `req` is don't-care until `rvalid`.
- `if_rdata` and `ls_rdata` hold their last captured value until the next read completion for that port.
- The memory command outputs hold the latched command outside ISSUE; only `mem_en` qualifies them.

## Timing
- **Reset values:** all outputs are 0 (`gnt`, `rvalid`, `rdata`, `mem_*`, `arb_busy`). FSM is in IDLE, counter is 0, `last_owner` is LS.
- **Transaction timeline** (grant in cycle T):
  - `mem_en` in cycle T+1.
  - `mem_rdata` valid in cycle T+1+`MEM_LAT`, sampled at the end of that cycle.
  - `rvalid` in cycle T+2+`MEM_LAT`.
  - Back in IDLE in cycle T+3+`MEM_LAT`; earliest next `gnt` is in that cycle.
- Each transaction occupies 3+`MEM_LAT` cycles. `arb_busy` is high from T+1 through T+2+`MEM_LAT`.
- **Reset mid-transaction:** the asynchronous reset aborts the transaction immediately.
  - No `rvalid` is issued for it.
  - `mem_en` drops at once.
  - `last_owner` returns to LS.
- Only one transaction is ever outstanding. There is no pipelining and no back-to-back overlap.

## Test plan
- **Single IF read, `MEM_LAT=1`:** `if_req` with `if_addr=0x10` and memory word 0xDEADBEEF.
  - Expect `if_gnt` at T, `mem_en` at T+1 with `mem_we=0` and `mem_addr=0x10`.
  - Expect `if_rvalid` at T+3 with `if_rdata=0xDEADBEEF`, then IDLE at T+4.
- **LS write then LS read of the same address:** write 0x0000CAFE to 0x20, then read 0x20.
  - Expect `mem_we=1` and `mem_wdata=0x0000CAFE` on the first ISSUE.
  - Expect `ls_rvalid` for both transactions, with the read returning 0x0000CAFE and `ls_rdata` unchanged after the write.
- **Continuous simultaneous requests:** both requesters hold `req` for 4 transactions.
  - Grant order must be IF, LS, IF, LS.
  - Grants must be spaced 3+`MEM_LAT` cycles apart.
- **`MEM_LAT=4` read:** grant at T.
  - Expect `rvalid` at T+6.
  - Expect `mem_rdata` driven only in cycle T+5 to be the value captured.
- **Reset during WAIT:** assert `resetn=0` in the second WAIT cycle.
  - All outputs must be 0 immediately and no `rvalid` may appear.
  - After release, a tie must be granted to IF.
- **Request withdrawn while busy:** pulse `ls_req` for 2 cycles during an IF transaction.
  - Expect no `ls_gnt` and no LS memory command.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter
// Shares the cpu's single-ported memory between instruction fetch (IF) and
// load/store (LS). One transaction at a time: grant in IDLE, one ISSUE
// cycle driving the memory command, MEM_LAT WAIT cycles, one RESP cycle
// pulsing the owner's rvalid. Ties go to whoever was not granted last.
//
// Ports:
//   clk, resetn               clock (rising edge), async active-low reset
//   if_req/if_addr            IF read request
//   if_gnt                    IF accepted (combinational, IDLE only)
//   if_rvalid/if_rdata        IF read completion strobe and held data
//   ls_req/ls_we/ls_addr/
//   ls_wdata                  LS read or write request
//   ls_gnt                    LS accepted (combinational, IDLE only)
//   ls_rvalid/ls_rdata        LS completion strobe and held read data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata       memory command and returned data
//   arb_busy                  high whenever the FSM is not in IDLE
module cpu_mem_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          arb_busy
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
      $error("cpu_mem_arbiter: MEM_LAT must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic       OWN_IF = 1'b0;
  localparam logic       OWN_LS = 1'b1;
  localparam logic [3:0] LAT_C  = 4'(MEM_LAT);

  state_t        state_r;
  state_t        next_state_s;
  logic          accept_s;
  logic          win_ls_s;
  logic          owner_r;
  logic          last_owner_r;
  logic          cmd_we_r;
  logic [AW-1:0] cmd_addr_r;
  logic [DW-1:0] cmd_wdata_r;
  logic [3:0]    cnt_r;
  logic [DW-1:0] if_rdata_r;
  logic [DW-1:0] ls_rdata_r;

  // Arbitration and next-state decode
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    win_ls_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (if_req && ls_req) begin
          // Tie: the requester that did not win last time goes first.
          accept_s = 1'b1;
          win_ls_s = (last_owner_r == OWN_IF);
        end else if (if_req) begin
          accept_s = 1'b1;
          win_ls_s = 1'b0;
        end else if (ls_req) begin
          accept_s = 1'b1;
          win_ls_s = 1'b1;
        end else begin
          accept_s = 1'b0;
          win_ls_s = 1'b0;
        end
        if (accept_s) begin
          next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: next_state_s = ST_WAIT;
      ST_WAIT: begin
        if (cnt_r == 4'd1) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RESP: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, latched command, latency counter and read-data capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWN_IF;
      last_owner_r <= OWN_LS;
      cmd_we_r     <= 1'b0;
      cmd_addr_r   <= {AW{1'b0}};
      cmd_wdata_r  <= {DW{1'b0}};
      cnt_r        <= 4'd0;
      if_rdata_r   <= {DW{1'b0}};
      ls_rdata_r   <= {DW{1'b0}};
    end else begin
      state_r <= next_state_s;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            owner_r      <= win_ls_s;
            last_owner_r <= win_ls_s;
            cmd_we_r     <= win_ls_s & ls_we;
            cmd_addr_r   <= win_ls_s ? ls_addr : if_addr;
            cmd_wdata_r  <= win_ls_s ? ls_wdata : {DW{1'b0}};
          end
        end
        ST_ISSUE: cnt_r <= LAT_C;
        ST_WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          // Final WAIT cycle: memory data is valid now; writes keep rdata.
          if (cnt_r == 4'd1 && !cmd_we_r) begin
            if (owner_r == OWN_LS) begin
              ls_rdata_r <= mem_rdata;
            end else begin
              if_rdata_r <= mem_rdata;
            end
          end
        end
        ST_RESP: cnt_r <= 4'd0;
        default: cnt_r <= 4'd0;
      endcase
    end
  end

  // Grants are masked during reset so nothing is accepted that will be lost.
  assign if_gnt    = resetn & accept_s & ~win_ls_s;
  assign ls_gnt    = resetn & accept_s & win_ls_s;
  assign if_rvalid = (state_r == ST_RESP) && (owner_r == OWN_IF);
  assign ls_rvalid = (state_r == ST_RESP) && (owner_r == OWN_LS);
  assign if_rdata  = if_rdata_r;
  assign ls_rdata  = ls_rdata_r;
  assign mem_en    = (state_r == ST_ISSUE);
  assign mem_we    = cmd_we_r;
  assign mem_addr  = cmd_addr_r;
  assign mem_wdata = cmd_wdata_r;
  assign arb_busy  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter. Instance A (MEM_LAT=1) runs a
// table of transactions scored through an expected-response queue, then
// round-robin and withdrawal sequences. Instance B (MEM_LAT=4) checks long
// latency capture and reset in the middle of WAIT.
module tb_cpu_mem_arbiter;
  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- instance A ----------------
  logic        resetn_a, if_req_a, if_gnt_a, if_rvalid_a, ls_req_a, ls_we_a;
  logic        ls_gnt_a, ls_rvalid_a, mem_en_a, mem_we_a, arb_busy_a;
  logic [7:0]  if_addr_a, ls_addr_a, mem_addr_a;
  logic [31:0] if_rdata_a, ls_wdata_a, ls_rdata_a, mem_wdata_a, mem_rdata_a;

  cpu_mem_arbiter #(.AW(8), .DW(32), .MEM_LAT(LAT_A)) dut_a (
    .clk(clk), .resetn(resetn_a),
    .if_req(if_req_a), .if_addr(if_addr_a), .if_gnt(if_gnt_a),
    .if_rvalid(if_rvalid_a), .if_rdata(if_rdata_a),
    .ls_req(ls_req_a), .ls_we(ls_we_a), .ls_addr(ls_addr_a), .ls_wdata(ls_wdata_a),
    .ls_gnt(ls_gnt_a), .ls_rvalid(ls_rvalid_a), .ls_rdata(ls_rdata_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .arb_busy(arb_busy_a)
  );

  // ---------------- instance B ----------------
  logic        resetn_b, if_req_b, if_gnt_b, if_rvalid_b, ls_req_b, ls_we_b;
  logic        ls_gnt_b, ls_rvalid_b, mem_en_b, mem_we_b, arb_busy_b;
  logic [7:0]  if_addr_b, ls_addr_b, mem_addr_b;
  logic [31:0] if_rdata_b, ls_wdata_b, ls_rdata_b, mem_wdata_b, mem_rdata_b;

  cpu_mem_arbiter #(.AW(8), .DW(32), .MEM_LAT(LAT_B)) dut_b (
    .clk(clk), .resetn(resetn_b),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b),
    .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
    .ls_req(ls_req_b), .ls_we(ls_we_b), .ls_addr(ls_addr_b), .ls_wdata(ls_wdata_b),
    .ls_gnt(ls_gnt_b), .ls_rvalid(ls_rvalid_b), .ls_rdata(ls_rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .arb_busy(arb_busy_b)
  );

  // ---------------- memory models ----------------
  // Read data is valid only in the cycle MEM_LAT after mem_en; junk otherwise.
  function automatic logic [31:0] preload(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {24'h5A5A5A, a};
  endfunction

  logic [31:0] mem_a [256];
  logic        wr_a  [256] = '{default: 1'b0};
  int          pend_a = 0;
  logic [7:0]  paddr_a = 8'h00;
  always @(posedge clk) begin
    if (mem_en_a && mem_we_a) begin
      mem_a[mem_addr_a] <= mem_wdata_a;
      wr_a[mem_addr_a]  <= 1'b1;
    end
    if (mem_en_a && !mem_we_a) begin
      pend_a  <= LAT_A;
      paddr_a <= mem_addr_a;
    end else if (pend_a != 0) begin
      pend_a <= pend_a - 1;
    end
  end
  assign mem_rdata_a = (pend_a == 1) ? (wr_a[paddr_a] ? mem_a[paddr_a] : preload(paddr_a))
                                     : 32'hBADBAD00;

  int         pend_b = 0;
  logic [7:0] paddr_b = 8'h00;
  always @(posedge clk) begin
    if (mem_en_b && !mem_we_b) begin
      pend_b  <= LAT_B;
      paddr_b <= mem_addr_b;
    end else if (pend_b != 0) begin
      pend_b <= pend_b - 1;
    end
  end
  assign mem_rdata_b = (pend_b == 1) ? {16'hA5A5, 8'h00, paddr_b} : 32'hBADBAD00;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not as required", name);
  endtask

  // ---------------- scoreboard for instance A ----------------
  typedef struct {
    logic        is_ls;
    logic [31:0] data;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  int mem_en_cnt_a = 0;
  int ls_gnt_cnt_a = 0;

  always @(negedge clk) begin
    if (resetn_a) begin
      if (mem_en_a) mem_en_cnt_a++;
      if (ls_gnt_a) ls_gnt_cnt_a++;
      if (if_rvalid_a && ls_rvalid_a) begin
        fail_now("rvalid_both");
      end else if (if_rvalid_a || ls_rvalid_a) begin
        if (sb_q.size() == 0) begin
          fail_now("rvalid_unexpected");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check({e.name, "_port"}, {63'd0, ls_rvalid_a}, {63'd0, e.is_ls});
          check({e.name, "_rdata"}, ls_rvalid_a ? ls_rdata_a : if_rdata_a, e.data);
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        is_ls;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;   // read data, or ls_rdata held unchanged for writes
    string       name;
  } vec_t;
  vec_t vecs[7];

  task automatic do_txn_a(input vec_t v);
    int   cyc;
    exp_t e;
    @(posedge clk); #1;
    if (v.is_ls) begin
      ls_req_a = 1'b1; ls_we_a = v.we; ls_addr_a = v.addr; ls_wdata_a = v.wdata;
    end else begin
      if_req_a = 1'b1; if_addr_a = v.addr;
    end
    @(negedge clk);  // cycle T
    check({v.name, "_gnt"}, {62'd0, if_gnt_a, ls_gnt_a}, v.is_ls ? 64'd1 : 64'd2);
    e.is_ls = v.is_ls; e.data = v.exp; e.name = v.name;
    sb_q.push_back(e);
    @(posedge clk); #1;
    if_req_a = 1'b0; ls_req_a = 1'b0;
    @(negedge clk);  // cycle T+1
    check({v.name, "_issue"}, {54'd0, mem_en_a, mem_we_a, mem_addr_a}, {54'd0, 1'b1, v.we, v.addr});
    if (v.we) check({v.name, "_wdata"}, mem_wdata_a, v.wdata);
    cyc = 1;
    while (!(if_rvalid_a || ls_rvalid_a) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({v.name, "_lat"}, cyc, LAT_A + 2);
    @(negedge clk);
    check({v.name, "_idle"}, {63'd0, arb_busy_a}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   cyc, last, gcount, m0, g0;
    logic rv_seen;
    exp_t e;

    resetn_a = 1'b0; resetn_b = 1'b0;
    if_req_a = 1'b0; if_addr_a = 8'h00; ls_req_a = 1'b0; ls_we_a = 1'b0;
    ls_addr_a = 8'h00; ls_wdata_a = 32'h0;
    if_req_b = 1'b0; if_addr_b = 8'h00; ls_req_b = 1'b0; ls_we_b = 1'b0;
    ls_addr_b = 8'h00; ls_wdata_b = 32'h0;

    vecs[0] = '{1'b0, 1'b0, 8'h10, 32'h0,         32'hDEADBEEF, "if_rd_10"};
    vecs[1] = '{1'b1, 1'b1, 8'h20, 32'h0000CAFE,  32'h00000000, "ls_wr_20"};
    vecs[2] = '{1'b1, 1'b0, 8'h20, 32'h0,         32'h0000CAFE, "ls_rd_20"};
    vecs[3] = '{1'b1, 1'b1, 8'h20, 32'h11112222,  32'h0000CAFE, "ls_wr_20b"};
    vecs[4] = '{1'b0, 1'b0, 8'h20, 32'h0,         32'h11112222, "if_rd_20"};
    vecs[5] = '{1'b1, 1'b0, 8'h30, 32'h0,         32'h5A5A5A30, "ls_rd_30"};
    vecs[6] = '{1'b0, 1'b0, 8'hFF, 32'h0,         32'h5A5A5AFF, "if_rd_ff"};

    repeat (2) @(posedge clk);
    #1 resetn_a = 1'b1; resetn_b = 1'b1;
    @(negedge clk);
    check("rst_a_ctl", {57'd0, if_gnt_a, if_rvalid_a, ls_gnt_a, ls_rvalid_a, mem_en_a, mem_we_a, arb_busy_a}, 64'd0);
    check("rst_a_rdata", {if_rdata_a, ls_rdata_a}, 64'd0);
    check("rst_a_mem", {24'd0, mem_addr_a, mem_wdata_a}, 64'd0);

    // Table of single transactions on A
    for (int i = 0; i < 7; i++) do_txn_a(vecs[i]);

    // Round robin from reset: both hold req, grants IF,LS,IF,LS, 3+LAT apart
    @(posedge clk); #1 resetn_a = 1'b0;
    @(posedge clk); #1 resetn_a = 1'b1;
    @(posedge clk); #1;
    if_req_a = 1'b1; if_addr_a = 8'h10;
    ls_req_a = 1'b1; ls_we_a = 1'b0; ls_addr_a = 8'h20;
    cyc = 0; last = 0; gcount = 0;
    while (gcount < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (if_gnt_a || ls_gnt_a) begin
        check($sformatf("rr_order_%0d", gcount), {62'd0, if_gnt_a, ls_gnt_a},
              (gcount % 2 == 0) ? 64'd2 : 64'd1);
        if (gcount > 0) check($sformatf("rr_gap_%0d", gcount), cyc - last, LAT_A + 3);
        e.is_ls = ls_gnt_a;
        e.data  = ls_gnt_a ? 32'h11112222 : 32'hDEADBEEF;
        e.name  = $sformatf("rr_txn_%0d", gcount);
        sb_q.push_back(e);
        last = cyc;
        gcount++;
      end
    end
    if (gcount < 4) fail_now("rr_timeout");
    @(posedge clk); #1 if_req_a = 1'b0; ls_req_a = 1'b0;
    repeat (LAT_A + 4) @(negedge clk);
    check("rr_sb_empty", sb_q.size(), 64'd0);

    // LS request pulsed for 2 cycles during an IF transaction: withdrawn
    @(posedge clk); #1 if_req_a = 1'b1; if_addr_a = 8'h10;
    @(negedge clk);
    check("wd_if_gnt", {63'd0, if_gnt_a}, 64'd1);
    e.is_ls = 1'b0; e.data = 32'hDEADBEEF; e.name = "wd_if_rd";
    sb_q.push_back(e);
    m0 = mem_en_cnt_a; g0 = ls_gnt_cnt_a;
    @(posedge clk); #1;
    if_req_a = 1'b0;
    ls_req_a = 1'b1; ls_we_a = 1'b1; ls_addr_a = 8'h77; ls_wdata_a = 32'h99999999;
    @(posedge clk); #1;
    @(posedge clk); #1 ls_req_a = 1'b0;
    repeat (8) @(negedge clk);
    check("wd_no_ls_gnt", ls_gnt_cnt_a - g0, 64'd0);
    check("wd_one_mem_cmd", mem_en_cnt_a - m0, 64'd1);
    check("wd_sb_empty", sb_q.size(), 64'd0);

    // Instance B: MEM_LAT=4 LS read, rvalid at T+6 with the T+5 data
    @(posedge clk); #1 ls_req_b = 1'b1; ls_we_b = 1'b0; ls_addr_b = 8'h33;
    @(negedge clk);
    check("b_ls_gnt", {63'd0, ls_gnt_b}, 64'd1);
    @(posedge clk); #1 ls_req_b = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ls_rvalid_b && cyc < 20);
    check("b_lat", cyc, LAT_B + 2);
    check("b_ls_rdata", ls_rdata_b, 32'hA5A50033);
    @(negedge clk);
    check("b_idle", {63'd0, arb_busy_b}, 64'd0);

    // Instance B: IF read aborted by reset in the second WAIT cycle
    @(posedge clk); #1 if_req_b = 1'b1; if_addr_b = 8'h44;
    @(negedge clk);  // T
    check("b_if_gnt", {63'd0, if_gnt_b}, 64'd1);
    @(posedge clk); #1 if_req_b = 1'b0;
    repeat (3) @(negedge clk);  // T+3, second WAIT cycle
    check("b_in_wait", {63'd0, arb_busy_b, mem_en_b}, 64'd2);
    #1 resetn_b = 1'b0;
    #1;
    check("b_rst_ctl", {57'd0, if_gnt_b, if_rvalid_b, ls_gnt_b, ls_rvalid_b, mem_en_b, mem_we_b, arb_busy_b}, 64'd0);
    check("b_rst_rdata", {if_rdata_b, ls_rdata_b}, 64'd0);
    check("b_rst_mem", {24'd0, mem_addr_b, mem_wdata_b}, 64'd0);
    rv_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      rv_seen = rv_seen | if_rvalid_b | ls_rvalid_b;
    end
    #1 resetn_b = 1'b1;
    repeat (6) begin
      @(negedge clk);
      rv_seen = rv_seen | if_rvalid_b | ls_rvalid_b;
    end
    check("b_no_rvalid", {63'd0, rv_seen}, 64'd0);

    // After reset the first tie goes to IF again
    @(posedge clk); #1;
    if_req_b = 1'b1; if_addr_b = 8'h01;
    ls_req_b = 1'b1; ls_we_b = 1'b0; ls_addr_b = 8'h02;
    @(negedge clk);
    check("b_tie_after_rst", {62'd0, if_gnt_b, ls_gnt_b}, 64'd2);
    @(posedge clk); #1 if_req_b = 1'b0; ls_req_b = 1'b0;
    repeat (LAT_B + 4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
